car_signal_ctrl: RTL and testbench

- Front-end controller that sequences the car_led lamp block.
- Turns raw driver controls (hazard push-button, turn stalk left/right, brake pedal) into the clean emergency/left/right/brake command levels that car_led consumes.
- Provides debounce, hazard toggle latching, left/right arbitration and turn-signal auto-cancel.
- Outputs connect one-to-one to car_led's emergency, left, right and brake inputs.

---
 rtl/car_signal_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_car_signal_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_signal_ctrl.sv
`default_nettype none
// ==================================================================
// car_signal_ctrl: debounced hazard/turn/brake sequencing for car_led
// Revision 1.0
// ==================================================================
module car_signal_ctrl #(
    parameter int DEB_CYC = 4,
    parameter int TIMEOUT = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic hazard_btn,
    input  logic stalk_left,
    input  logic stalk_right,
    input  logic brake_pedal,
    output logic emergency,
    output logic left,
    output logic right,
    output logic brake,
    output logic auto_cancel
);

    localparam int c_CNT_W = $clog2(DEB_CYC + 1);
    localparam int c_TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LEFT     = 2'd1,
        ST_RIGHT    = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    // Bit 0 hazard, bit 1 left stalk, bit 2 right stalk.
    logic [2:0] w_raw;
    logic [2:0] w_db;
    logic [2:0] r_db_prev;
    logic [2:0] w_rise;

    assign w_raw  = {stalk_right, stalk_left, hazard_btn};
    assign w_rise = w_db & ~r_db_prev;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_deb
            logic               r_db_bit;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_db_bit <= 1'b0;
                    r_cnt    <= '0;
                end else if (w_raw[g] == r_db_bit) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_W'(DEB_CYC - 1)) begin
                    r_db_bit <= w_raw[g];
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_db[g] = r_db_bit;
        end
    endgenerate

    state_t               r_state;
    state_t               w_next_state;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_TMR_W-1:0]   w_next_timer;
    logic                 r_wait_left;
    logic                 w_next_wait_left;
    logic                 w_cancel;
    logic                 r_hazard_on;
    logic                 r_left;
    logic                 r_right;
    logic                 r_brake;
    logic                 r_auto_cancel;

    logic w_rise_haz;
    logic w_rise_l;
    logic w_rise_r;
    logic w_db_l;
    logic w_db_r;

    assign w_rise_haz = w_rise[0];
    assign w_rise_l   = w_rise[1];
    assign w_rise_r   = w_rise[2];
    assign w_db_l     = w_db[1];
    assign w_db_r     = w_db[2];

    always_comb begin
        w_next_state     = r_state;
        w_next_timer     = r_timer;
        w_next_wait_left = r_wait_left;
        w_cancel         = 1'b0;
        // Any hazard toggle, or hazard already on, parks the turn logic.
        if (r_hazard_on || w_rise_haz) begin
            w_next_state = ST_IDLE;
            w_next_timer = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise_l && !w_db_r) begin
                        w_next_state = ST_LEFT;
                        w_next_timer = '0;
                    end else if (w_rise_r && !w_db_l) begin
                        w_next_state = ST_RIGHT;
                        w_next_timer = '0;
                    end
                end
                ST_LEFT: begin
                    if (w_rise_r) begin
                        w_next_state = ST_RIGHT;
                        w_next_timer = '0;
                    end else if (!w_db_l) begin
                        w_next_state = ST_IDLE;
                    end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
                        w_next_state     = ST_WAIT_REL;
                        w_next_wait_left = 1'b1;
                        w_cancel         = 1'b1;
                    end else begin
                        w_next_timer = r_timer + 1'b1;
                    end
                end
                ST_RIGHT: begin
                    if (w_rise_l) begin
                        w_next_state = ST_LEFT;
                        w_next_timer = '0;
                    end else if (!w_db_r) begin
                        w_next_state = ST_IDLE;
                    end else if (r_timer == c_TMR_W'(TIMEOUT - 1)) begin
                        w_next_state     = ST_WAIT_REL;
                        w_next_wait_left = 1'b0;
                        w_cancel         = 1'b1;
                    end else begin
                        w_next_timer = r_timer + 1'b1;
                    end
                end
                ST_WAIT_REL: begin
                    // Only the opposite stalk may restart from here.
                    if (r_wait_left && w_rise_r) begin
                        w_next_state = ST_RIGHT;
                        w_next_timer = '0;
                    end else if (!r_wait_left && w_rise_l) begin
                        w_next_state = ST_LEFT;
                        w_next_timer = '0;
                    end else if (!w_db_l && !w_db_r) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                    w_next_timer = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_wait_left   <= 1'b0;
            r_db_prev     <= '0;
            r_hazard_on   <= 1'b0;
            r_left        <= 1'b0;
            r_right       <= 1'b0;
            r_brake       <= 1'b0;
            r_auto_cancel <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_timer       <= w_next_timer;
            r_wait_left   <= w_next_wait_left;
            r_db_prev     <= w_db;
            r_hazard_on   <= r_hazard_on ^ w_rise_haz;
            r_left        <= (w_next_state == ST_LEFT);
            r_right       <= (w_next_state == ST_RIGHT);
            r_brake       <= brake_pedal;
            r_auto_cancel <= w_cancel;
        end
    end

    assign emergency   = r_hazard_on;
    assign left        = r_left;
    assign right       = r_right;
    assign brake       = r_brake;
    assign auto_cancel = r_auto_cancel;

endmodule
`default_nettype wire

// File: tb/tb_car_signal_ctrl.sv
`default_nettype none
// ==================================================================
// tb_car_signal_ctrl: scenario and random checks against a lamp model
// Revision 1.0
// ==================================================================
module tb_car_signal_ctrl;

    localparam int DEB_CYC = 4;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic hazard_btn = 1'b0;
    logic stalk_left = 1'b0;
    logic stalk_right = 1'b0;
    logic brake_pedal = 1'b0;
    logic emergency, left, right, brake, auto_cancel;

    int errors = 0;
    int checks = 0;

    car_signal_ctrl #(.DEB_CYC(DEB_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .hazard_btn(hazard_btn),
        .stalk_left(stalk_left), .stalk_right(stalk_right),
        .brake_pedal(brake_pedal), .emergency(emergency), .left(left),
        .right(right), .brake(brake), .auto_cancel(auto_cancel)
    );

    always #5 clk = ~clk;

    // Lamp model: index 0 hazard, 1 left stalk, 2 right stalk.
    // m_side: 0 nothing lit, 1 left lit, 2 right lit.
    bit m_db[3];
    bit m_prev[3];
    int m_run[3];
    bit m_haz, m_brake, m_ac, m_waiting;
    int m_side, m_wait_side, m_elapsed;

    task automatic model_step();
        bit raw[3];
        bit odb[3];
        bit rise[3];
        bit old_haz;
        int opp;
        raw[0] = hazard_btn; raw[1] = stalk_left; raw[2] = stalk_right;
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_db[i] = 0; m_prev[i] = 0; m_run[i] = 0;
            end
            m_haz = 0; m_brake = 0; m_ac = 0; m_waiting = 0;
            m_side = 0; m_wait_side = 0; m_elapsed = 0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            odb[i]  = m_db[i];
            rise[i] = m_db[i] && !m_prev[i];
            m_prev[i] = m_db[i];
            if (raw[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB_CYC) begin
                    m_db[i]  = raw[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_brake = brake_pedal;
        m_ac    = 0;
        old_haz = m_haz;
        if (rise[0]) m_haz = !m_haz;
        if (old_haz || rise[0]) begin
            m_side = 0; m_waiting = 0;
        end else if (m_waiting) begin
            opp = (m_wait_side == 1) ? 2 : 1;
            if (rise[opp]) begin
                m_side = opp; m_waiting = 0; m_elapsed = 0;
            end else if (!odb[1] && !odb[2]) begin
                m_waiting = 0;
            end
        end else if (m_side == 0) begin
            if (rise[1] && !odb[2]) begin
                m_side = 1; m_elapsed = 0;
            end else if (rise[2] && !odb[1]) begin
                m_side = 2; m_elapsed = 0;
            end
        end else begin
            opp = 3 - m_side;
            if (rise[opp]) begin
                m_side = opp; m_elapsed = 0;
            end else if (!odb[m_side]) begin
                m_side = 0;
            end else if (m_elapsed == TIMEOUT - 1) begin
                m_waiting = 1; m_wait_side = m_side; m_side = 0; m_ac = 1;
            end else begin
                m_elapsed++;
            end
        end
    endtask

    function automatic logic [4:0] ev();
        return {m_haz, m_side == 1, m_side == 2, m_brake, m_ac};
    endfunction

    function automatic logic [4:0] dv();
        return {emergency, left, right, brake, auto_cancel};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            hazard_btn = 1'(i); stalk_left = 1'(~i); stalk_right = 1'(i);
            brake_pedal = 1'b1;
            tick();
            checks++;
            if (dv() !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b want 00000", dv());
            end
        end
        hazard_btn = 0; stalk_left = 0; stalk_right = 0; brake_pedal = 0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_brake();
        brake_pedal = 1'b1;
        tick();
        checks++;
        if (brake !== 1'b1 || dv() !== ev()) begin
            errors++;
            $display("FAIL brake_on: got %b want brake=1 vec %b", dv(), ev());
        end
        brake_pedal = 1'b0;
        tick();
        checks++;
        if (brake !== 1'b0 || dv() !== ev()) begin
            errors++;
            $display("FAIL brake_off: got %b want brake=0 vec %b", dv(), ev());
        end
    endtask

    task automatic test_debounce_left();
        int n;
        int acs;
        stalk_left = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) stalk_left = 1'b0;
            tick();
            checks++;
            if (left !== 1'b0 || dv() !== ev()) begin
                errors++;
                $display("FAIL glitch: got %b want left=0 vec %b", dv(), ev());
            end
        end
        stalk_left = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (left === 1'b1) break;
        end
        checks++;
        if (n != DEB_CYC + 1) begin
            errors++;
            $display("FAIL left_latency: got %0d edges want %0d", n, DEB_CYC + 1);
        end
        stalk_left = 1'b0;
        n = 0; acs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            acs += int'(auto_cancel);
            if (left === 1'b0) break;
        end
        checks++;
        if (n != DEB_CYC + 1 || acs != 0) begin
            errors++;
            $display("FAIL left_release: got %0d edges %0d cancels want %0d edges 0 cancels",
                     n, acs, DEB_CYC + 1);
        end
    endtask

    task automatic test_auto_cancel();
        int hi;
        int acs;
        int n;
        stalk_left = 1'b1;
        hi = 0; acs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            hi  += int'(left);
            acs += int'(auto_cancel);
            checks++;
            if (dv() !== ev()) begin
                errors++;
                $display("FAIL cancel_trace: got %b want %b", dv(), ev());
            end
        end
        checks++;
        if (hi != TIMEOUT || acs != 1 || left !== 1'b0) begin
            errors++;
            $display("FAIL auto_cancel: got high=%0d pulses=%0d left=%b want %0d 1 0",
                     hi, acs, left, TIMEOUT);
        end
        stalk_left = 1'b0;
        repeat (8) tick();
        stalk_left = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n++;
            if (left === 1'b1) break;
        end
        checks++;
        if (left !== 1'b1 || n != DEB_CYC + 1) begin
            errors++;
            $display("FAIL repress_left: got left=%b after %0d edges want 1 after %0d",
                     left, n, DEB_CYC + 1);
        end
    endtask

    task automatic test_switch();
        int hi;
        repeat (3) tick();
        stalk_right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (right === 1'b1) break;
        end
        checks++;
        if (right !== 1'b1 || left !== 1'b0) begin
            errors++;
            $display("FAIL switch_edge: got left=%b right=%b want 0 1", left, right);
        end
        hi = 1;
        for (int i = 0; i < 30; i++) begin
            tick();
            hi += int'(right);
            checks++;
            if (dv() !== ev()) begin
                errors++;
                $display("FAIL switch_trace: got %b want %b", dv(), ev());
            end
        end
        checks++;
        if (hi != TIMEOUT) begin
            errors++;
            $display("FAIL switch_timer: got right high %0d want %0d", hi, TIMEOUT);
        end
        stalk_left = 1'b0; stalk_right = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_hazard();
        bit seen;
        stalk_right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (right === 1'b1) break;
        end
        tick();
        hazard_btn = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (emergency === 1'b1 && !seen) begin
                seen = 1;
                checks++;
                if (right !== 1'b0) begin
                    errors++;
                    $display("FAIL hazard_kill_right: got right=%b want 0", right);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL hazard_on: got emergency=%b want 1", emergency);
        end
        hazard_btn = 1'b0;
        repeat (8) tick();
        stalk_right = 1'b0; stalk_left = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (left !== 1'b0 || right !== 1'b0 || dv() !== ev()) begin
                errors++;
                $display("FAIL hazard_ignore: got %b want %b", dv(), ev());
            end
        end
        hazard_btn = 1'b1;
        repeat (6) tick();
        hazard_btn = 1'b0;
        checks++;
        if (emergency !== 1'b0) begin
            errors++;
            $display("FAIL hazard_off: got emergency=%b want 0", emergency);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (left !== 1'b0 || dv() !== ev()) begin
                errors++;
                $display("FAIL held_no_relight: got %b want %b", dv(), ev());
            end
        end
        stalk_left = 1'b0;
        repeat (8) tick();
        stalk_left = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (left === 1'b1) break;
        end
        checks++;
        if (left !== 1'b1) begin
            errors++;
            $display("FAIL relight_after_hazard: got left=%b want 1", left);
        end
    endtask

    task automatic test_conflict_reset();
        stalk_left = 1'b0;
        repeat (8) tick();
        stalk_left = 1'b1; stalk_right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (left !== 1'b0 || right !== 1'b0 || dv() !== ev()) begin
                errors++;
                $display("FAIL conflict: got %b want %b", dv(), ev());
            end
        end
        stalk_left = 1'b0; stalk_right = 1'b0;
        repeat (8) tick();
        stalk_left = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (left === 1'b1) break;
        end
        repeat (10) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (dv() !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b want 00000", dv());
        end
        for (int i = 1; i <= DEB_CYC + 1; i++) begin
            tick();
            checks++;
            if (left !== ((i == DEB_CYC + 1) ? 1'b1 : 1'b0) || dv() !== ev()) begin
                errors++;
                $display("FAIL post_reset_rise: edge %0d got %b want %b", i, dv(), ev());
            end
        end
        stalk_left = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(11) == 0) hazard_btn  = ~hazard_btn;
            if ($urandom_range(7) == 0)  stalk_left  = ~stalk_left;
            if ($urandom_range(7) == 0)  stalk_right = ~stalk_right;
            brake_pedal = 1'($urandom_range(1));
            reset = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (dv() !== ev()) begin
                errors++;
                $display("FAIL random cycle %0d: got %b want %b", i, dv(), ev());
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_brake();
        test_debounce_left();
        test_auto_cancel();
        test_switch();
        test_hazard();
        test_conflict_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
